// File: rtl/spi_frame_loader_if.sv
// Bundles the SPI pins and the bram write port of the frame loader.
// The slave modport faces the loader; the master modport faces the host/bench.
interface spi_frame_loader_if #(
    parameter int ADDRESS_WIDTH = 9
);
    logic                     spi_sclk;
    logic                     spi_mosi;
    logic                     spi_cs_n;
    logic                     wen;
    logic [ADDRESS_WIDTH-1:0] waddr;
    logic [7:0]               wdata;
    logic                     frame_done;
    logic                     overflow;

    modport slave (
        input  spi_sclk,
        input  spi_mosi,
        input  spi_cs_n,
        output wen,
        output waddr,
        output wdata,
        output frame_done,
        output overflow
    );

    modport master (
        output spi_sclk,
        output spi_mosi,
        output spi_cs_n,
        input  wen,
        input  waddr,
        input  wdata,
        input  frame_done,
        input  overflow
    );
endinterface

// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that streams LED frame bytes into the pixel bram write port.
// Each transaction: 2-byte big-endian start address, then channel bytes written
// to consecutive addresses. Out-of-range bytes are dropped and flagged.
module spi_frame_loader #(
    parameter int MEMORY_SIZE   = 480,
    parameter int ADDRESS_WIDTH = 9
) (
    input  logic clk,
    input  logic rst,
    spi_frame_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        DATA
    } state_t;

    localparam logic [15:0] MEM_LIMIT = 16'(MEMORY_SIZE);

    // Synchronizer chains: index 1 is the synchronized level, index 2 the previous one.
    logic [2:0] sclk_sync_reg;
    logic [2:0] cs_sync_reg;
    logic [1:0] mosi_sync_reg;

    logic sclk_rise;
    logic cs_n_s;
    logic cs_rise;
    logic mosi_s;

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt_reg;
    logic       byte_valid;
    logic [7:0] byte_next;

    state_t                   state_reg;
    logic [7:0]               addr_hi_reg;
    logic [15:0]              ptr_reg;
    logic                     written_reg;
    logic                     wen_reg;
    logic [ADDRESS_WIDTH-1:0] waddr_reg;
    logic [7:0]               wdata_reg;
    logic                     frame_done_reg;
    logic                     overflow_reg;

    // Bring the asynchronous SPI pins into the clk domain; reset loads idle levels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync_reg <= 3'b000;
            cs_sync_reg   <= 3'b111;
            mosi_sync_reg <= 2'b00;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], bus.spi_sclk};
            cs_sync_reg   <= {cs_sync_reg[1:0], bus.spi_cs_n};
            mosi_sync_reg <= {mosi_sync_reg[0], bus.spi_mosi};
        end
    end

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign cs_n_s    = cs_sync_reg[1];
    assign cs_rise   = cs_sync_reg[1] & ~cs_sync_reg[2];
    assign mosi_s    = mosi_sync_reg[1];

    // A byte completes on the eighth rising sclk; cs_n must be low, so a byte
    // can never complete in the same cycle as cs_rise.
    assign byte_next  = {shift_reg[6:0], mosi_s};
    assign byte_valid = (state_reg != IDLE) && sclk_rise && !cs_n_s && (bit_cnt_reg == 3'd7);

    // Shift MOSI in MSB first; the counter is held clear while idle so a
    // partial byte from an aborted transaction never leaks into the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg   <= 8'h00;
            bit_cnt_reg <= 3'd0;
        end else if (state_reg == IDLE) begin
            bit_cnt_reg <= 3'd0;
        end else if (sclk_rise && !cs_n_s) begin
            shift_reg   <= byte_next;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
    end

    // Transaction FSM: parse the address, then issue one registered write per data byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            addr_hi_reg    <= 8'h00;
            ptr_reg        <= 16'h0000;
            written_reg    <= 1'b0;
            wen_reg        <= 1'b0;
            waddr_reg      <= '0;
            wdata_reg      <= 8'h00;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            wen_reg        <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!cs_n_s) begin
                        written_reg <= 1'b0;
                        state_reg   <= ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    if (cs_rise) begin
                        state_reg <= IDLE;
                    end else if (byte_valid) begin
                        addr_hi_reg <= byte_next;
                        state_reg   <= ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (cs_rise) begin
                        state_reg <= IDLE;
                    end else if (byte_valid) begin
                        ptr_reg   <= {addr_hi_reg, byte_next};
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        // Any final write was already issued in an earlier cycle,
                        // so this pulse always follows the last wen.
                        frame_done_reg <= written_reg;
                        state_reg      <= IDLE;
                    end else if (byte_valid) begin
                        if (ptr_reg < MEM_LIMIT) begin
                            wen_reg     <= 1'b1;
                            waddr_reg   <= ptr_reg[ADDRESS_WIDTH-1:0];
                            wdata_reg   <= byte_next;
                            written_reg <= 1'b1;
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                        if (ptr_reg != 16'hFFFF) begin
                            ptr_reg <= ptr_reg + 16'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.wen        = wen_reg;
    assign bus.waddr      = waddr_reg;
    assign bus.wdata      = wdata_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed + randomized bench for spi_frame_loader. Expected writes are derived
// from the transaction bytes by plain address arithmetic.
module tb_spi_frame_loader;

    localparam int MEM = 480;

    logic clk;
    logic rst;

    spi_frame_loader_if #(.ADDRESS_WIDTH(9)) bus ();

    spi_frame_loader #(.MEMORY_SIZE(MEM), .ADDRESS_WIDTH(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int obs_q[$];
    int exp_q[$];
    logic [7:0] tx_q[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int last_wen_cyc = -1;
    int adjacent_cnt = 0;
    bit prev_wen = 1'b0;
    bit ovf_model = 1'b0;

    always @(posedge clk) cyc++;

    // Monitor: record every write and frame_done pulse away from the active edge.
    always @(negedge clk) begin
        if (bus.wen === 1'b1) begin
            obs_q.push_back((int'(bus.waddr) << 8) | int'(bus.wdata));
            last_wen_cyc = cyc;
            if (prev_wen) adjacent_cnt++;
        end
        prev_wen = (bus.wen === 1'b1);
        if (bus.frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            bus.spi_mosi = b[7-k];
            repeat (4) @(negedge clk);
            bus.spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        last_wen_cyc = -1;
        adjacent_cnt = 0;
    endtask

    // Reference: address is the first two bytes, data goes to addr, addr+1, ...
    // with the pointer saturating at 0xFFFF; anything at or beyond MEM is dropped.
    task automatic build_expect();
        int addr;
        int p;
        exp_q.delete();
        if (tx_q.size() >= 2) begin
            addr = (int'(tx_q[0]) << 8) | int'(tx_q[1]);
            for (int i = 2; i < tx_q.size(); i++) begin
                p = addr + (i - 2);
                if (p > 65535) p = 65535;
                if (p < MEM) exp_q.push_back((p << 8) | int'(tx_q[i]));
                else ovf_model = 1'b1;
            end
        end
    endtask

    task automatic run_txn(input int partial_bits);
        clear_obs();
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        foreach (tx_q[i]) send_bits(tx_q[i], 8);
        if (partial_bits > 0) send_bits(8'($urandom), partial_bits);
        repeat (4) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic compare_txn(input string name);
        int n;
        build_expect();
        check({name, "_nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({name, "_write"}, obs_q[i], exp_q[i]);
        check({name, "_done_cnt"}, done_cnt, (exp_q.size() > 0) ? 1 : 0);
        if (exp_q.size() > 0) check({name, "_done_after_wen"}, 32'(done_cyc > last_wen_cyc), 1);
        check({name, "_overflow"}, bus.overflow, ovf_model);
        $display("txn %s: writes=%0d expected=%0d done=%0d overflow=%0b", name,
                 obs_q.size(), exp_q.size(), done_cnt, bus.overflow);
    endtask

    initial begin
        int addr;
        int len;

        // Reset with random SPI activity.
        rst = 1'b0;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("rst_wen", bus.wen, 0);
            check("rst_frame_done", bus.frame_done, 0);
            check("rst_overflow", bus.overflow, 0);
            check("rst_waddr", bus.waddr, 0);
            bus.spi_sclk = 1'($urandom);
            bus.spi_mosi = 1'($urandom);
            bus.spi_cs_n = 1'($urandom);
        end
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_cs_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        clear_obs();
        repeat (8) @(negedge clk);
        check("idle_wen_count", obs_q.size(), 0);
        check("idle_frame_done", bus.frame_done, 0);
        check("idle_overflow", bus.overflow, 0);
        check("idle_wdata", bus.wdata, 0);

        // Basic frame.
        tx_q = '{8'h00, 8'h00, 8'hAA, 8'h55, 8'h01};
        run_txn(0);
        compare_txn("basic");

        // Abort after one address byte, then a clean transaction.
        tx_q = '{8'h01};
        run_txn(0);
        compare_txn("abort_addr");
        tx_q = '{8'h00, 8'h10, 8'hC3};
        run_txn(0);
        compare_txn("after_abort");

        // Abort 5 bits into a data byte.
        tx_q = '{8'h00, 8'h20, 8'h9A};
        run_txn(5);
        compare_txn("abort_data");

        // Max-rate stress: whole memory.
        tx_q.delete();
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        for (int i = 0; i < MEM; i++) tx_q.push_back(8'(i % 256));
        run_txn(0);
        compare_txn("stress");
        check("stress_adjacent_wen", adjacent_cnt, 0);

        // Random transactions around the top of memory.
        for (int t = 0; t < 4; t++) begin
            addr = $urandom_range(0, 520);
            len = $urandom_range(1, 8);
            tx_q.delete();
            tx_q.push_back(8'(addr >> 8));
            tx_q.push_back(8'(addr));
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
            run_txn(0);
            compare_txn($sformatf("rand%0d", t));
        end

        // Boundary: 478, 479 written, third dropped.
        tx_q = '{8'h01, 8'hDE, 8'h11, 8'h22, 8'h33};
        run_txn(0);
        compare_txn("boundary");

        // Pointer saturation at 0xFFFF: everything dropped, no frame_done.
        tx_q = '{8'hFF, 8'hFE, 8'h01, 8'h02, 8'h03};
        run_txn(0);
        compare_txn("saturate");

        // Reset during the 10th data byte.
        clear_obs();
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(8'h00, 8);
        send_bits(8'h00, 8);
        for (int i = 0; i < 9; i++) send_bits(8'(8'h40 + i), 8);
        send_bits(8'hF0, 4);
        rst = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        ovf_model = 1'b0;
        repeat (8) @(negedge clk);
        check("midrst_nwrites", obs_q.size(), 9);
        for (int i = 0; i < 9 && i < obs_q.size(); i++)
            check("midrst_write", obs_q[i], (i << 8) | (8'h40 + i));
        check("midrst_done_cnt", done_cnt, 0);
        check("midrst_overflow", bus.overflow, 0);
        $display("txn midrst: writes=%0d expected=9 done=%0d", obs_q.size(), done_cnt);
        tx_q = '{8'h00, 8'h05, 8'h7E};
        run_txn(0);
        compare_txn("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
